// File: rtl/digital_basics_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding, default width,
// and a gate-level incrementer so the controller carries no '+' of its own.
package digital_basics_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SERIAL_ADD_WIDTH_DEF = 8;

  // Widest index counter needed: WIDTH<=32 -> $clog2(32)+1 = 6 bits.
  localparam int IDX_W_MAX = 6;

  // Ripple incrementer built from XOR/AND so the shared full adder stays
  // the only arithmetic element in the controller.
  function automatic logic [IDX_W_MAX-1:0] idx_inc(input logic [IDX_W_MAX-1:0] v);
    logic [IDX_W_MAX-1:0] r;
    logic                 c;
    c = 1'b1;
    for (int i = 0; i < IDX_W_MAX; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and serial_adder_ctrl.
// ovf only exists when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if
  import digital_basics_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/full_adder_beh.sv
// One-bit behavioural full adder; the single arithmetic cell that the
// serial controller time-shares across bit positions.
module full_adder_beh (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic [1:0] tot;

  // Two-bit total of three one-bit inputs.
  assign tot    = {1'b0, a_i} + {1'b0, b_i} + {1'b0, cin_i};
  assign sum_o  = tot[0];
  assign cout_o = tot[1];
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches operands on start, feeds one bit
// per clock (LSB first) through a shared full_adder_beh, then publishes a
// registered sum/cout with a one-cycle done pulse.
// Optional: SERIAL_ADD_OVF_EN adds a registered signed-overflow output.
module serial_adder_ctrl
  import digital_basics_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int                IDX_W    = $clog2(WIDTH) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, sum_sh_q;
  logic [WIDTH-1:0]   sum_sh_d;
  logic               carry_q;
  logic               busy_q, done_q, cout_q;
  logic [WIDTH-1:0]   sum_q;
  logic               fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q;
`endif

  full_adder_beh u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_s),
    .cout_o (fa_co)
  );

  // New sum bit enters from the MSB side so bit 0 lands at [0] after WIDTH steps.
  always_comb begin
    sum_sh_d            = sum_sh_q >> 1;
    sum_sh_d[WIDTH-1]   = fa_s;
  end

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
            carry_q  <= bus.cin;
            sum_sh_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_co;
          idx_q    <= IDX_W'(idx_inc(IDX_W_MAX'(idx_q)));
          if (idx_q == LAST_IDX) begin
            sum_q   <= sum_sh_d;
            cout_q  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q is the carry into the MSB on this last step.
            ovf_q   <= carry_q ^ fa_co;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule
